// File: rtl/fa_pkg.sv
// ============================================================================
// Module      : fa_pkg
// Description : Shared constants, result word type and overflow helper for the
//               registered ripple-carry adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fa_pkg;

    localparam int FA_DEFAULT_WIDTH = 4;

    // {cout, s} as one word at the default width
    typedef logic [FA_DEFAULT_WIDTH:0] fa_result_t;

    function automatic logic fa_signed_ovf(input logic c_into_msb, input logic c_out_of_msb);
        return c_into_msb ^ c_out_of_msb;
    endfunction

endpackage : fa_pkg

`default_nettype wire

// File: rtl/full_adder_bit.sv
// ============================================================================
// Module      : full_adder_bit
// Description : Single-bit combinational full-adder cell.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder_bit
    import fa_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder_bit

`default_nettype wire

// File: rtl/fa_4bit_bh.sv
// ============================================================================
// Module      : fa_4bit_bh
// Description : Registered ripple-carry adder with carry-out, signed overflow
//               and a valid bit that travels alongside the result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fa_4bit_bh
    import fa_pkg::*;
#(
    parameter int WIDTH = FA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid
);

    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;

    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ovf;
    logic             r_out_valid;

    assign w_c[0] = cin;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            full_adder_bit u_cell (
                .a    (a[gi]),
                .b    (b[gi]),
                .cin  (w_c[gi]),
                .s    (w_sum[gi]),
                .cout (w_c[gi+1])
            );
        end
    endgenerate

    assign w_ovf = fa_signed_ovf(w_c[WIDTH-1], w_c[WIDTH]);

    // Data registers hold when idle; only the valid bit drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s         <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_s    <= w_sum;
                r_cout <= w_c[WIDTH];
                r_ovf  <= w_ovf;
            end
        end
    end

    assign s         = r_s;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign out_valid = r_out_valid;

endmodule : fa_4bit_bh

`default_nettype wire

// File: tb/tb_fa_4bit_bh.sv
// ============================================================================
// Module      : tb_fa_4bit_bh
// Description : Self-checking bench for fa_4bit_bh (directed table + sequences).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fa_4bit_bh;
    import fa_pkg::*;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] s;
        logic       cout;
        logic       ovf;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] s;
    logic       cout;
    logic       ovf;
    logic       out_valid;

    int n_vec;
    int n_err;

    vec_t tbl [11];

    fa_4bit_bh #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] es, input logic ec,
                       input logic eo, input logic ev);
        n_vec++;
        if (s !== es || cout !== ec || ovf !== eo || out_valid !== ev) begin
            n_err++;
            $display("FAIL %s: got s=%b cout=%b ovf=%b out_valid=%b, want s=%b cout=%b ovf=%b out_valid=%b",
                     name, s, cout, ovf, out_valid, es, ec, eo, ev);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] ta, input logic [3:0] tb_,
                         input logic tc);
        in_valid = v;
        a        = ta;
        b        = tb_;
        cin      = tc;
    endtask

    initial begin
        fa_result_t exp_word;
        int         sa, sb, ssum;
        logic       exp_ovf;
        logic [3:0] pa, pb;
        logic       pc;

        n_vec = 0;
        n_err = 0;

        tbl[0]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[1]  = '{4'b0001, 4'b0001, 1'b1, 4'b0011, 1'b0, 1'b0};
        tbl[2]  = '{4'b0010, 4'b0010, 1'b0, 4'b0100, 1'b0, 1'b0};
        tbl[3]  = '{4'b0011, 4'b0011, 1'b1, 4'b0111, 1'b0, 1'b0};
        tbl[4]  = '{4'b0100, 4'b0100, 1'b0, 4'b1000, 1'b0, 1'b1};
        tbl[5]  = '{4'b0101, 4'b0101, 1'b1, 4'b1011, 1'b0, 1'b1};
        tbl[6]  = '{4'b0111, 4'b0111, 1'b0, 4'b1110, 1'b0, 1'b1};
        tbl[7]  = '{4'b1110, 4'b1110, 1'b1, 4'b1101, 1'b1, 1'b0};
        tbl[8]  = '{4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b1, 1'b0};
        tbl[9]  = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0};
        tbl[10] = '{4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0};

        // Asynchronous reset mid-cycle, no clock edge involved
        rst_n = 1'b1;
        drive(1'b0, 4'b0000, 4'b0000, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk("reset_async", 4'b0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("reset_held", 4'b0000, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_release", 4'b0000, 1'b0, 1'b0, 1'b0);

        // Directed sweep, one vector per cycle, results one edge later
        drive(1'b1, tbl[0].a, tbl[0].b, tbl[0].cin);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            chk($sformatf("sweep[%0d]", i), tbl[i].s, tbl[i].cout, tbl[i].ovf, 1'b1);
            if (i < 10) drive(1'b1, tbl[i+1].a, tbl[i+1].b, tbl[i+1].cin);
            else        drive(1'b0, 4'b0000, 4'b0000, 1'b0);
        end
        @(negedge clk);
        chk("sweep_drain", 4'b0000, 1'b1, 1'b0, 1'b0);

        // Hold: outputs keep the last result while in_valid is low
        drive(1'b1, 4'b0011, 4'b0011, 1'b1);
        @(negedge clk);
        chk("hold_capture", 4'b0111, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 4'b1010, 4'b0101, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("hold[%0d]", i), 4'b0111, 1'b0, 1'b0, 1'b0);
        end

        // Reset during a valid stream: in-flight result is discarded
        drive(1'b1, 4'b0111, 4'b0111, 1'b0);
        @(negedge clk);
        chk("stream_before_rst", 4'b1110, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 4'b0001, 4'b0001, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk("rst_midstream", 4'b0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("rst_with_valid", 4'b0000, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 4'b0101, 4'b0001, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("no_stale_valid", 4'b0000, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 4'b0101, 4'b0001, 1'b1);
        @(negedge clk);
        chk("first_after_rst", 4'b0111, 1'b0, 1'b0, 1'b1);

        // Exhaustive back-to-back: check the previous vector each cycle
        for (int k = 0; k < 513; k++) begin
            if (k > 0) begin
                @(negedge clk);
                exp_word = 5'(pa) + 5'(pb) + 5'(pc);
                sa = (pa >= 4'd8) ? int'(pa) - 16 : int'(pa);
                sb = (pb >= 4'd8) ? int'(pb) - 16 : int'(pb);
                ssum = sa + sb + int'(pc);
                exp_ovf = (ssum > 7) || (ssum < -8);
                chk($sformatf("exh a=%b b=%b cin=%b", pa, pb, pc),
                    exp_word[3:0], exp_word[4], exp_ovf, 1'b1);
            end
            if (k < 512) begin
                pa = 4'(k >> 5);
                pb = 4'(k >> 1);
                pc = k[0];
                drive(1'b1, pa, pb, pc);
            end else begin
                drive(1'b0, 4'b0000, 4'b0000, 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_fa_4bit_bh

`default_nettype wire
